// File: rtl/square_recon_if.sv
// Operand/result handshake bundle for square_recon.
// The producer/consumer side uses master; the reconstruction unit uses slave.
interface square_recon_if #(
  parameter int W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   root;
  logic [W:0]     rem;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] num;
  logic           exact;
  logic           err;

  modport master (
    output in_valid,
    output root,
    output rem,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  num,
    input  exact,
    input  err
  );

  modport slave (
    input  in_valid,
    input  root,
    input  rem,
    input  out_ready,
    output in_ready,
    output out_valid,
    output num,
    output exact,
    output err
  );
endinterface

// File: rtl/square_recon.sv
// Rebuilds num = root*root + rem with a one-bit-per-clock shift-add squarer,
// and regenerates the perfect-square and illegal-remainder flags.
module square_recon #(
  parameter int W = 8
) (
  input  logic        CLK,
  input  logic        RST,
  square_recon_if.slave bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int AW = 2 * W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_reg;
  logic [W-1:0]    rroot_reg;
  logic [W:0]      rrem_reg;
  logic [AW-1:0]   acc_reg;
  logic [CW-1:0]   cnt_reg;
  logic [2*W-1:0]  num_reg;
  logic            exact_reg;
  logic            err_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;

  logic [AW-1:0]   pp [W];
  logic [AW-1:0]   mul_next;
  logic [AW-1:0]   add_next;
  logic            err_next;

  // Partial product for each root bit; MUL picks the one for the current cnt.
  for (genvar gi = 0; gi < W; gi++) begin : g_pp
    assign pp[gi] = rroot_reg[gi] ? (AW'(rroot_reg) << gi) : '0;
  end

  assign mul_next = acc_reg + pp[cnt_reg];
  assign add_next = acc_reg + AW'(rrem_reg);
  // Both sides widened to W+2 bits so 2*root cannot wrap.
  assign err_next = ({1'b0, rrem_reg} > {1'b0, rroot_reg, 1'b0});

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      rroot_reg     <= '0;
      rrem_reg      <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      num_reg       <= '0;
      exact_reg     <= 1'b0;
      err_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            rroot_reg    <= bus.root;
            rrem_reg     <= bus.rem;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= MUL;
          end
        end
        MUL: begin
          acc_reg <= mul_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(W - 1)) begin
            state_reg <= ADD;
          end
        end
        ADD: begin
          acc_reg       <= add_next;
          num_reg       <= add_next[2*W-1:0];
          exact_reg     <= (rrem_reg == '0);
          err_reg       <= err_next;
          out_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.num       = num_reg;
  assign bus.exact     = exact_reg;
  assign bus.err       = err_reg;

endmodule
